squeeze1x1_engine: RTL and testbench

Fire-module squeeze stage placed directly downstream of `maxpool2d`. It accepts one 64-channel pooled pixel at a time (16-bit signed Q8.8 per channel) and computes a 1x1 convolution against 16 filters held in an internal weight/bias register file. It adds bias, applies ReLU with saturation, and emits a 16-channel pixel vector. It also counts pixels per frame and flags the last pixel of the 55x55 pooled map.

---
 rtl/squeeze1x1_engine_if.sv | 29 ++
 rtl/squeeze1x1_engine.sv | 146 ++++++++++++++
 tb/tb_squeeze1x1_engine.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/squeeze1x1_engine_if.sv
// Pixel-in / weight-load / squeeze-out bundle for squeeze1x1_engine.
// master = upstream stage plus weight loader; slave = the engine.
// Valid/ready on pixels; writes use a plain strobe; results are single-cycle pulses.
interface squeeze1x1_engine_if #(
    parameter int CIN  = 64,
    parameter int COUT = 16,
    parameter int DW   = 16
);
    logic                 i_data_valid;
    logic [CIN*DW-1:0]    inp;
    logic                 i_ready;
    logic                 w_wr_en;
    logic [3:0]           w_addr;
    logic [CIN*DW-1:0]    w_data;
    logic [DW-1:0]        b_data;
    logic [COUT*DW-1:0]   squeezeout;
    logic                 squeezevalid;
    logic                 frame_done;

    modport master (
        output i_data_valid, inp, w_wr_en, w_addr, w_data, b_data,
        input  i_ready, squeezeout, squeezevalid, frame_done
    );

    modport slave (
        input  i_data_valid, inp, w_wr_en, w_addr, w_data, b_data,
        output i_ready, squeezeout, squeezevalid, frame_done
    );
endinterface

// File: rtl/squeeze1x1_engine.sv
// 1x1 squeeze convolution: 64ch Q8.8 pixel x 16 filters, bias, ReLU + saturate.
// Latency: 16 cycles from acceptance to squeezevalid; one filter evaluated per cycle.
// Backpressure: i_ready low during COMPUTE; valid is ignored (not queued) while busy.
// Ports: clk, rst (async active-high); bus (slave modport) carries the pixel
// handshake, the weight/bias write port, squeezeout/squeezevalid and frame_done.
module squeeze1x1_engine #(
    parameter int CIN  = 64,
    parameter int COUT = 16,
    parameter int DW   = 16,
    parameter int FRAC = 8,
    parameter int NPIX = 3025
) (
    input  logic               clk,
    input  logic               rst,
    squeeze1x1_engine_if.slave bus
);
    localparam int ACCW = 40;
    localparam int CW   = $clog2(NPIX);
    localparam logic [3:0]    F_LAST = 4'(COUT - 1);
    localparam logic [CW-1:0] C_LAST = CW'(NPIX - 1);
    localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((1 << (DW - 1)) - 1);

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [CIN*DW-1:0]      r_inp;
    logic [CIN*DW-1:0]      r_w [COUT];
    logic [DW-1:0]          r_b [COUT];
    logic [COUT*DW-1:0]     r_out;
    logic [3:0]             r_f;
    logic [CW-1:0]          r_pix_cnt;

    logic                   w_ready;
    logic                   w_accept;
    logic                   w_valid_pulse;
    logic                   w_frame_done;
    logic                   w_wr_ok;

    logic signed [DW-1:0]   w_a;
    logic signed [DW-1:0]   w_b;
    logic signed [2*DW-1:0] w_p;
    logic signed [ACCW-1:0] w_acc;
    logic signed [ACCW-1:0] w_shr;
    logic [DW-1:0]          w_res;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_ready       = (r_state != COMPUTE);
        w_accept      = bus.i_data_valid && w_ready;
        w_valid_pulse = 1'b0;
        w_frame_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next = COMPUTE;
            end
            COMPUTE: begin
                if (r_f == F_LAST) w_next = DONE;
            end
            DONE: begin
                w_valid_pulse = 1'b1;
                // Pulse on the pixel that brings the count up to NPIX.
                w_frame_done  = (r_pix_cnt == C_LAST);
                w_next        = w_accept ? COMPUTE : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Writes share the not-busy window with pixel acceptance, so a write and
    // an acceptance on the same edge feed the new weights to the new pixel.
    assign w_wr_ok = bus.w_wr_en && (r_state != COMPUTE);

    // ---------------- Dot product for filter r_f ----------------
    always_comb begin
        w_a   = '0;
        w_b   = '0;
        w_p   = '0;
        // Bias is Q8.8; aligning it with Q16.16 products needs a FRAC shift.
        w_acc = ACCW'(signed'(r_b[r_f])) <<< FRAC;
        for (int c = 0; c < CIN; c++) begin
            w_a   = r_inp[c*DW +: DW];
            w_b   = r_w[r_f][c*DW +: DW];
            w_p   = w_a * w_b;
            w_acc = w_acc + ACCW'(w_p);
        end
        // Arithmetic shift floors toward -inf, then ReLU and clamp.
        w_shr = w_acc >>> FRAC;
        if (w_shr < 0) begin
            w_res = '0;
        end else if (w_shr > SAT_MAX) begin
            w_res = SAT_MAX[DW-1:0];
        end else begin
            w_res = w_shr[DW-1:0];
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inp     <= '0;
            r_f       <= '0;
            r_out     <= '0;
            r_pix_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_inp <= bus.inp;
                r_f   <= '0;
            end else if (r_state == COMPUTE) begin
                r_out[r_f*DW +: DW] <= w_res;
                r_f                 <= r_f + 4'd1;
            end
            if (r_state == DONE) begin
                r_pix_cnt <= (r_pix_cnt == C_LAST) ? '0 : r_pix_cnt + CW'(1);
            end
        end
    end

    // ---------------- Weight / bias register file ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int f = 0; f < COUT; f++) begin
                r_w[f] <= '0;
                r_b[f] <= '0;
            end
        end else if (w_wr_ok) begin
            r_w[bus.w_addr] <= bus.w_data;
            r_b[bus.w_addr] <= bus.b_data;
        end
    end

    assign bus.i_ready      = w_ready;
    assign bus.squeezeout   = r_out;
    assign bus.squeezevalid = w_valid_pulse;
    assign bus.frame_done   = w_frame_done;

endmodule

// File: tb/tb_squeeze1x1_engine.sv
// Directed bench for squeeze1x1_engine: latency, arithmetic corners, streaming,
// write gating, frame counting and asynchronous reset.
module tb_squeeze1x1_engine;
    localparam int CIN  = 64;
    localparam int COUT = 16;
    localparam int DW   = 16;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    squeeze1x1_engine_if #(.CIN(CIN), .COUT(COUT), .DW(DW)) bus();

    squeeze1x1_engine #(.CIN(CIN), .COUT(COUT), .DW(DW), .FRAC(8), .NPIX(3025)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_filter(input logic [3:0] f, input logic [15:0] wv, input logic [15:0] bv);
        bus.w_wr_en = 1'b1;
        bus.w_addr  = f;
        bus.w_data  = {CIN{wv}};
        bus.b_data  = bv;
        tick;
        bus.w_wr_en = 1'b0;
    endtask

    // Offers one pixel, waits for squeezevalid. lat counts edges after acceptance.
    // wr_mid issues a filter-0 zero-weight write while the engine is busy.
    task automatic run_pixel(input logic [15:0] val, input bit wr_mid,
                             output int lat, output logic [255:0] out, output logic fd);
        bus.inp          = {CIN{val}};
        bus.i_data_valid = 1'b1;
        for (int k = 0; k < 40 && !bus.i_ready; k++) tick;
        tick;
        bus.i_data_valid = 1'b0;
        lat = 0;
        while (!bus.squeezevalid && lat < 40) begin
            if (wr_mid && lat == 3) begin
                bus.w_wr_en = 1'b1;
                bus.w_addr  = 4'd0;
                bus.w_data  = '0;
                bus.b_data  = '0;
            end
            tick;
            bus.w_wr_en = 1'b0;
            lat++;
        end
        out = bus.squeezeout;
        fd  = bus.frame_done;
    endtask

    int           lat;
    logic [255:0] out;
    logic         fd;
    int           acc, svc, last, lowrun, badrun, badint, badout, fd_ok, fd_bad;
    logic [255:0] all4000;

    initial begin
        rst              = 1'b1;
        bus.i_data_valid = 1'b0;
        bus.inp          = '0;
        bus.w_wr_en      = 1'b0;
        bus.w_addr       = '0;
        bus.w_data       = '0;
        bus.b_data       = '0;
        all4000          = {COUT{16'h4000}};
        repeat (2) tick;

        // Reset state
        chk("rst_ready", bus.i_ready, 1);
        chk("rst_valid", bus.squeezevalid, 0);
        chk("rst_fdone", bus.frame_done, 0);
        chk("rst_out",   bus.squeezeout, 0);
        rst = 1'b0;
        tick;

        // Unity weights, unity input: 64 * 1.0 = 64.0 -> 0x4000
        for (int f = 0; f < COUT; f++) load_filter(4'(f), 16'h0100, 16'h0000);
        run_pixel(16'h0100, 0, lat, out, fd);
        chk("basic_lat", lat, 16);
        chk("basic_out", out, all4000);
        chk("basic_fd",  fd, 0);
        tick;
        chk("valid_one_cycle", bus.squeezevalid, 0);

        // 64 * 2.0 = 128.0 exceeds Q8.8 range -> saturate
        run_pixel(16'h0200, 0, lat, out, fd);
        chk("sat_slot1", out[1*16 +: 16], 16'h7FFF);

        // Negative weights -> ReLU clamps to zero
        load_filter(4'd3, 16'hFF00, 16'h0000);
        run_pixel(16'h0100, 0, lat, out, fd);
        chk("relu_slot3", out[3*16 +: 16], 16'h0000);
        chk("relu_slot0", out[0*16 +: 16], 16'h4000);

        // Bias-only filter
        load_filter(4'd2, 16'h0000, 16'h0180);
        run_pixel(16'h0100, 0, lat, out, fd);
        chk("bias_pos_a", out[2*16 +: 16], 16'h0180);
        run_pixel(16'h0200, 0, lat, out, fd);
        chk("bias_pos_b", out[2*16 +: 16], 16'h0180);
        load_filter(4'd2, 16'h0000, 16'hFF80);
        run_pixel(16'h0100, 0, lat, out, fd);
        chk("bias_neg", out[2*16 +: 16], 16'h0000);

        // Back-to-back streaming with valid held high
        tick;
        bus.inp          = {CIN{16'h0100}};
        bus.i_data_valid = 1'b1;
        acc = 0; svc = 0; last = -1; lowrun = 0; badrun = 0; badint = 0; badout = 0;
        for (int k = 0; k < 400 && (acc < 10 || svc < 10); k++) begin
            if (bus.squeezevalid) begin
                svc++;
                if (bus.squeezeout[15:0] !== 16'h4000) badout++;
            end
            if (!bus.i_ready) begin
                lowrun++;
            end else begin
                if (lowrun != 0 && lowrun != 16) badrun++;
                lowrun = 0;
            end
            if (bus.i_ready && bus.i_data_valid) begin
                acc++;
                if (last >= 0 && k - last != 17) badint++;
                last = k;
            end
            tick;
            if (acc == 10) bus.i_data_valid = 1'b0;
        end
        chk("b2b_accepts",   acc, 10);
        chk("b2b_outputs",   svc, 10);
        chk("b2b_interval",  badint, 0);
        chk("b2b_ready_low", badrun, 0);
        chk("b2b_data",      badout, 0);

        // Write during COMPUTE is dropped; write while idle lands
        run_pixel(16'h0100, 1, lat, out, fd);
        chk("midwr_cur",  out[15:0], 16'h4000);
        run_pixel(16'h0100, 0, lat, out, fd);
        chk("midwr_next", out[15:0], 16'h4000);
        load_filter(4'd0, 16'h0000, 16'h0000);
        run_pixel(16'h0100, 0, lat, out, fd);
        chk("idlewr", out[15:0], 16'h0000);

        // Frame boundary: 3025 pixels then one more, counter starts at 0 after reset
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tick;
        bus.inp          = {CIN{16'h0100}};
        bus.i_data_valid = 1'b1;
        acc = 0; svc = 0; fd_ok = 0; fd_bad = 0;
        for (int k = 0; k < 60000 && svc < 3026; k++) begin
            if (bus.squeezevalid) begin
                svc++;
                if (bus.frame_done) begin
                    if (svc == 3025) fd_ok++;
                    else fd_bad++;
                end
            end else if (bus.frame_done) begin
                fd_bad++;
            end
            if (bus.i_ready && bus.i_data_valid) acc++;
            tick;
            if (acc == 3026) bus.i_data_valid = 1'b0;
        end
        chk("frame_count", svc, 3026);
        chk("frame_done_3025", fd_ok, 1);
        chk("frame_done_other", fd_bad, 0);

        // Reset in the middle of COMPUTE
        load_filter(4'd0, 16'h0100, 16'h0000);
        run_pixel(16'h0100, 0, lat, out, fd);
        chk("pre_rst_out", out[15:0], 16'h4000);
        tick;
        bus.i_data_valid = 1'b1;
        tick;
        bus.i_data_valid = 1'b0;
        repeat (5) tick;
        rst = 1'b1;
        #1;
        chk("midrst_valid", bus.squeezevalid, 0);
        chk("midrst_out",   bus.squeezeout, 0);
        chk("midrst_ready", bus.i_ready, 1);
        chk("midrst_fd",    bus.frame_done, 0);
        tick;
        rst = 1'b0;
        svc = 0;
        for (int k = 0; k < 30; k++) begin
            if (bus.squeezevalid) svc++;
            tick;
        end
        chk("midrst_no_valid", svc, 0);
        run_pixel(16'h0100, 0, lat, out, fd);
        chk("post_rst_lat", lat, 16);
        chk("post_rst_w_cleared", out, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
